serial_adder: RTL



---
 rtl/serial_adder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: computes a + b + cin LSB first, one bit per clock,
// using a two-half-adder cell and a single carry flop between bits.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             busy,
  output logic             done
);

  // Counter must reach WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic ha1_s, ha1_c, ha2_s, ha2_c;
  logic bit_s, bit_c;
  logic accept;

  // Two cascaded half adders; either stage may generate the carry.
  assign ha1_s = a_sh_q[0] ^ b_sh_q[0];
  assign ha1_c = a_sh_q[0] & b_sh_q[0];
  assign ha2_s = ha1_s ^ carry_q;
  assign ha2_c = ha1_s & carry_q;
  assign bit_s = ha2_s;
  assign bit_c = ha1_c | ha2_c;

  // start is only honoured outside SHIFT, which gives the back-to-back path from DONE.
  assign accept = start && (state_q != SHIFT);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    co_d    = co_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      SHIFT: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        res_d   = {bit_s, res_q[WIDTH-1:1]};
        carry_d = bit_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = {bit_s, res_q[WIDTH-1:1]};
          co_d    = bit_c;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = SHIFT;
      a_sh_d  = a;
      b_sh_d  = b;
      carry_d = cin;
      res_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sum  = sum_q;
  assign co   = co_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
